rom_stream_ctrl: RTL and testbench

ROM_STREAM_CTRL -- requirements
Module: rom_stream_ctrl

---
 rtl/rom_stream_ctrl_pkg.sv | 19 +
 rtl/rom_stream_ctrl.sv | 137 +++++++++++++
 tb/tb_rom_stream_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_ctrl_pkg.sv
// ============================================================================
// rom_stream_ctrl_pkg : shared widths, burst limit and FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package rom_stream_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int MAX_LEN = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rom_stream_ctrl.sv
// ============================================================================
// rom_stream_ctrl : reads a burst of words from an external combinational ROM
//                   and streams them out over a valid/ready port with checksum
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_stream_ctrl
  import rom_stream_ctrl_pkg::*;
#(
  parameter int DATA_W = rom_stream_ctrl_pkg::DATA_W,
  parameter int ADDR_W = rom_stream_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] c_max_len = (ADDR_W+1)'(MAX_LEN);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  logic              w_xfer;
  logic              w_load;
  logic [ADDR_W:0]   w_len_sat;

  assign w_xfer    = valid_q && out_ready;
  assign w_load    = (state_q == S_STREAM) && (!valid_q || out_ready) && (rem_q != '0);
  assign w_len_sat = (len > c_max_len) ? c_max_len : len;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    csum_d  = csum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = w_len_sat;
          csum_d = '0;
          if (w_len_sat != '0) begin
            state_d = S_STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_STREAM, S_DRAIN: begin
        if (w_xfer) begin
          csum_d = csum_q + data_q;
        end
        // A load refills the output register in the same edge the old beat leaves.
        if (w_load) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          last_d  = (rem_q == (ADDR_W+1)'(1));
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = S_DRAIN;
          end
        end else if (w_xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        if ((state_q == S_DRAIN) && w_xfer && last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      csum_q  <= csum_d;
    end
  end

  assign rom_addr  = addr_q;
  assign busy      = (state_q != S_IDLE);
  assign rom_cs    = busy;
  assign rom_rd_en = w_load;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign checksum  = csum_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_ctrl.sv
// ============================================================================
// tb_rom_stream_ctrl : directed self-checking bench for rom_stream_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rom_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] len;
  logic [2:0] rom_addr;
  logic       rom_cs;
  logic       rom_rd_en;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  logic [7:0] rom_mem [8];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q  [$];
  logic       last_q [$];
  int         done_cnt;
  int         first_xfer_k;
  int         last_xfer_k;
  int         valid_cnt;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  rom_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_rd_en (rom_rd_en),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: out_ready always high; mode 1: 1,0,0,1,1 then high.
  // inj_k >= 0 pulses start (base 5, len 4) at that cycle of the burst.
  task automatic run_burst(input logic [2:0] b, input logic [3:0] l, input int mode,
                           input int inj_k, input int ncyc);
    logic [7:0] hold_data;
    logic [2:0] hold_addr;
    logic       hold_last;
    logic       holding;
    logic [4:0] pat;
    got_q.delete();
    last_q.delete();
    done_cnt     = 0;
    first_xfer_k = -1;
    last_xfer_k  = -1;
    valid_cnt    = 0;
    holding      = 1'b0;
    hold_data    = '0;
    hold_addr    = '0;
    hold_last    = 1'b0;
    pat          = 5'b11001;
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    len       = l;
    out_ready = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      out_ready = (mode == 1 && k < 5) ? pat[k] : 1'b1;
      if (k == inj_k) begin
        start     = 1'b1;
        base_addr = 3'd5;
        len       = 4'd4;
      end else begin
        start = 1'b0;
      end
      #1;
      if (holding) begin
        check("hold_data", out_data, hold_data);
        check("hold_addr", rom_addr, hold_addr);
        check("hold_last", out_last, hold_last);
      end
      holding = 1'b0;
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        if (first_xfer_k < 0) first_xfer_k = k;
        last_xfer_k = k;
      end
      if (out_valid && !out_ready) begin
        check("rd_en_hold", rom_rd_en, 0);
        holding   = 1'b1;
        hold_data = out_data;
        hold_addr = rom_addr;
        hold_last = out_last;
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", busy, 0);
      end
    end
    start     = 1'b0;
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp [$], input logic [7:0] exp_cs);
    check({tag, "_nbeats"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      check({tag, "_beat"}, got_q[i], exp[i]);
      check({tag, "_last"}, last_q[i], (i == exp.size() - 1) ? 1 : 0);
    end
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_csum"}, checksum, exp_cs);
  endtask

  initial begin
    logic [7:0] e [$];
    rom_mem = '{8'd99, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77};
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last",  out_last, 0);
    check("rst_done",  done, 0);
    check("rst_busy",  busy, 0);
    check("rst_cs",    rom_cs, 0);
    check("rst_rd_en", rom_rd_en, 0);
    check("rst_data",  out_data, 0);
    check("rst_addr",  rom_addr, 0);
    check("rst_csum",  checksum, 0);
    rst = 1'b0;

    // Full burst, no back-pressure
    run_burst(3'd0, 4'd8, 0, -1, 14);
    e = '{8'd99, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77};
    check_stream("full8", e, 8'd151);
    check("full8_first_k", first_xfer_k, 1);
    check("full8_nobubble", last_xfer_k - first_xfer_k, 7);

    // Address wrap
    run_burst(3'd6, 4'd4, 0, -1, 10);
    e = '{8'd66, 8'd77, 8'd99, 8'd11};
    check_stream("wrap", e, 8'd253);

    // Back-pressure
    run_burst(3'd1, 4'd3, 1, -1, 12);
    e = '{8'd11, 8'd22, 8'd33};
    check_stream("bp", e, 8'd66);
    check("bp_first_k", first_xfer_k, 3);

    // Zero length
    run_burst(3'd3, 4'd0, 0, -1, 5);
    check("len0_valid", valid_cnt, 0);
    check("len0_done", done_cnt, 1);
    check("len0_csum", checksum, 0);

    // Length saturation
    run_burst(3'd0, 4'd12, 0, -1, 16);
    e = '{8'd99, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77};
    check_stream("sat", e, 8'd151);

    // Reset mid-burst, after two beats have transferred
    @(negedge clk);
    start     = 1'b1;
    base_addr = 3'd0;
    len       = 4'd8;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last",  out_last, 0);
    check("mid_rst_done",  done, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_cs",    rom_cs, 0);
    check("mid_rst_data",  out_data, 0);
    check("mid_rst_addr",  rom_addr, 0);
    check("mid_rst_csum",  checksum, 0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid_rst_nodone", done_cnt, 0);
    run_burst(3'd2, 4'd1, 0, -1, 6);
    e = '{8'd22};
    check_stream("after_rst", e, 8'd22);

    // start during a burst is ignored
    run_burst(3'd0, 4'd4, 0, 2, 14);
    e = '{8'd99, 8'd11, 8'd22, 8'd33};
    check_stream("ign_start", e, 8'd165);
    check("ign_start_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
